// File: rtl/xbar_cfg_ctrl.sv
// xbar_cfg_ctrl -- configuration sequencer for the LUT-tile input crossbar.
// Collects the mux-select bitstream word by word into a shadow register and
// applies it to the crossbar in one step when a commit is requested, so the
// crossbar never sees a half-written select set.
//
// Ports:
//   clk, reset       single clock, synchronous active-high reset
//   io_cfg_valid/    config word handshake (valid in, ready out);
//   io_cfg_ready     ready is low only while an image waits for commit
//   io_cfg_data      config word, word 0 carries the LSBs of the image
//   io_cfg_last      marks the final word of an image
//   io_commit        apply the pending shadow image
//   io_abort         discard any partial or pending image
//   io_mux_configs   active selects, field i at [i*SEL_W +: SEL_W]
//   io_cfg_pending   complete image waiting for commit
//   io_cfg_done      one-cycle pulse when a commit takes effect
//   io_cfg_err       sticky error flag for the last load attempt
//
// Optional feature: define XBAR_CFG_RANGE_CHECK_EN to reject images that
// contain a select field >= N_IN.
module xbar_cfg_ctrl #(
  parameter int N_IN   = 15,
  parameter int N_OUT  = 16,
  parameter int SEL_W  = 4,
  parameter int WORD_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_cfg_valid,
  output logic                     io_cfg_ready,
  input  logic [WORD_W-1:0]        io_cfg_data,
  input  logic                     io_cfg_last,
  input  logic                     io_commit,
  input  logic                     io_abort,
  output logic [N_OUT*SEL_W-1:0]   io_mux_configs,
  output logic                     io_cfg_pending,
  output logic                     io_cfg_done,
  output logic                     io_cfg_err
);

  localparam int CFG_W  = N_OUT * SEL_W;
  localparam int NWORDS = CFG_W / WORD_W;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [CFG_W-1:0]  shadow_q;
  logic [CFG_W-1:0]  mux_q;
  logic              pending_q;
  logic              done_q;
  logic              err_q;
  logic              range_q;

  logic              beat;
  logic              is_final;
  logic              field_bad;
  logic              load_bad;

  assign io_cfg_ready   = (state_q != HOLD);
  assign io_mux_configs = mux_q;
  assign io_cfg_pending = pending_q;
  assign io_cfg_done    = done_q;
  assign io_cfg_err     = err_q;

  assign beat = io_cfg_valid & io_cfg_ready;

  // wcnt is 0 whenever the FSM sits in IDLE, so the same compare covers the
  // single-word image case in IDLE and the normal final word in LOAD.
  assign is_final = (wcnt_q == LAST_IDX);

`ifdef XBAR_CFG_RANGE_CHECK_EN
  localparam int FIELDS = WORD_W / SEL_W;
  localparam logic [SEL_W:0] NIN_L = (SEL_W + 1)'(N_IN);

  always_comb begin
    field_bad = 1'b0;
    for (int unsigned f = 0; f < FIELDS; f++) begin
      if ({1'b0, io_cfg_data[f*SEL_W +: SEL_W]} >= NIN_L) begin
        field_bad = 1'b1;
      end
    end
  end
`else
  assign field_bad = 1'b0;
`endif

  // Range flag of the words already accepted only counts while in LOAD.
  assign load_bad = field_bad | ((state_q == LOAD) & range_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      shadow_q  <= '0;
      mux_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      range_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (io_abort) begin
        state_q   <= IDLE;
        wcnt_q    <= '0;
        pending_q <= 1'b0;
        range_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, LOAD: begin
            if (beat) begin
              for (int unsigned k = 0; k < NWORDS; k++) begin
                if (wcnt_q == WCNT_W'(k)) begin
                  shadow_q[k*WORD_W +: WORD_W] <= io_cfg_data;
                end
              end
              // A new load attempt clears the previous error; a later
              // assignment in this branch may set it again.
              if (state_q == IDLE) begin
                err_q <= 1'b0;
              end
              if (io_cfg_last != is_final) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
                wcnt_q  <= '0;
                range_q <= 1'b0;
              end else if (is_final) begin
                wcnt_q  <= '0;
                range_q <= 1'b0;
                if (load_bad) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  state_q   <= HOLD;
                  pending_q <= 1'b1;
                end
              end else begin
                wcnt_q  <= wcnt_q + WCNT_W'(1);
                range_q <= load_bad;
                state_q <= LOAD;
              end
            end
          end
          HOLD: begin
            if (io_commit) begin
              mux_q     <= shadow_q;
              done_q    <= 1'b1;
              pending_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
          default: begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            pending_q <= 1'b0;
            range_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xbar_cfg_ctrl.sv
module tb_xbar_cfg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_cfg_valid;
  logic        io_cfg_ready;
  logic [7:0]  io_cfg_data;
  logic        io_cfg_last;
  logic        io_commit;
  logic        io_abort;
  logic [63:0] io_mux_configs;
  logic        io_cfg_pending;
  logic        io_cfg_done;
  logic        io_cfg_err;

  xbar_cfg_ctrl #(
    .N_IN   (15),
    .N_OUT  (16),
    .SEL_W  (4),
    .WORD_W (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_cfg_valid   (io_cfg_valid),
    .io_cfg_ready   (io_cfg_ready),
    .io_cfg_data    (io_cfg_data),
    .io_cfg_last    (io_cfg_last),
    .io_commit      (io_commit),
    .io_abort       (io_abort),
    .io_mux_configs (io_mux_configs),
    .io_cfg_pending (io_cfg_pending),
    .io_cfg_done    (io_cfg_done),
    .io_cfg_err     (io_cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;

  sb_t sbq[$];

  // Active image as the bench expects it on io_mux_configs.
  logic [63:0] mux_m;

  task automatic sb_push(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic sb_cmp(input logic [63:0] obs);
    sb_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_mis++;
      $error("FAIL sb_empty observed=%h expected=<queued entry>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_st(input string step, input logic [63:0] mux,
                           input logic pend, input logic done,
                           input logic err, input logic rdy);
    sb_push({step, ".mux"},     mux);
    sb_push({step, ".pending"}, {63'd0, pend});
    sb_push({step, ".done"},    {63'd0, done});
    sb_push({step, ".err"},     {63'd0, err});
    sb_push({step, ".ready"},   {63'd0, rdy});
  endtask

  task automatic check_st();
    sb_cmp(io_mux_configs);
    sb_cmp({63'd0, io_cfg_pending});
    sb_cmp({63'd0, io_cfg_done});
    sb_cmp({63'd0, io_cfg_err});
    sb_cmp({63'd0, io_cfg_ready});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive words from..to of img back to back; last asserted on word lastpos.
  task automatic send_range(input logic [63:0] img, input int from,
                            input int to, input int lastpos);
    for (int i = from; i <= to; i++) begin
      io_cfg_valid = 1'b1;
      io_cfg_data  = img[i*8 +: 8];
      io_cfg_last  = (i == lastpos);
      tick();
    end
    io_cfg_valid = 1'b0;
    io_cfg_last  = 1'b0;
    io_cfg_data  = 8'h00;
  endtask

  task automatic do_commit();
    io_commit = 1'b1;
    tick();
    io_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] img_a;
    logic [63:0] img_b;
    logic [63:0] img_r;
    logic [63:0] img_e;
    img_a = 64'h0EDCBA9876543210;
    img_b = 64'h0123456789ABCDE0;
    img_r = 64'hF0F0F0F0F0F0F0F0;
    img_e = 64'hEEEEEEEEEEEEEEEE;
    mux_m = '0;

    reset        = 1'b1;
    io_cfg_valid = 1'b0;
    io_cfg_data  = 8'h00;
    io_cfg_last  = 1'b0;
    io_commit    = 1'b0;
    io_abort     = 1'b0;
    tick();
    expect_st("reset", 64'd0, 0, 0, 0, 1);
    tick();
    check_st();
    reset = 1'b0;
    expect_st("post_reset", 64'd0, 0, 0, 0, 1);
    tick();
    check_st();

    // Normal load: not pending after 7 words, pending right after word 7.
    expect_st("load7", mux_m, 0, 0, 0, 1);
    send_range(img_a, 0, 6, 7);
    check_st();
    expect_st("load8", mux_m, 1, 0, 0, 0);
    send_range(img_a, 7, 7, 7);
    check_st();
    expect_st("commit", img_a, 0, 1, 0, 1);
    do_commit();
    check_st();
    mux_m = img_a;
    expect_st("done_pulse", mux_m, 0, 0, 0, 1);
    tick();
    check_st();

    // Early last on word 3.
    expect_st("early_last", mux_m, 0, 0, 1, 1);
    send_range(64'h1111111111111111, 0, 3, 3);
    check_st();
    expect_st("err_clear", mux_m, 0, 0, 0, 1);
    send_range(64'd0, 0, 0, 7);
    check_st();
    expect_st("zero_load", mux_m, 1, 0, 0, 0);
    send_range(64'd0, 1, 7, 7);
    check_st();

    // Abort and commit together in HOLD: abort wins.
    expect_st("abort_commit", mux_m, 0, 0, 0, 1);
    io_abort  = 1'b1;
    io_commit = 1'b1;
    tick();
    io_abort  = 1'b0;
    io_commit = 1'b0;
    check_st();
    expect_st("abort_nodone", mux_m, 0, 0, 0, 1);
    tick();
    check_st();

    // Missing last on word 7, then commit in IDLE is ignored.
    expect_st("missing_last", mux_m, 0, 0, 1, 1);
    send_range(64'h2222222222222222, 0, 7, 8);
    check_st();
    expect_st("idle_commit", mux_m, 0, 0, 1, 1);
    do_commit();
    check_st();

    // Abort together with an accepted beat mid-load drops the beat.
    send_range(img_b, 0, 2, 7);
    expect_st("abort_beat", mux_m, 0, 0, 0, 1);
    io_abort     = 1'b1;
    io_cfg_valid = 1'b1;
    io_cfg_data  = 8'hFF;
    tick();
    io_abort     = 1'b0;
    io_cfg_valid = 1'b0;
    check_st();
    expect_st("reload_b", mux_m, 1, 0, 0, 0);
    send_range(img_b, 0, 7, 7);
    check_st();

    // Backpressure in HOLD: held valid not consumed.
    io_cfg_valid = 1'b1;
    io_cfg_data  = 8'hFF;
    io_cfg_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_st("hold_bp", mux_m, 1, 0, 0, 0);
      tick();
      check_st();
    end
    io_cfg_valid = 1'b0;
    io_cfg_last  = 1'b0;
    expect_st("commit_b", img_b, 0, 1, 0, 1);
    do_commit();
    check_st();
    mux_m = img_b;

    // Select value 15 is out of range; 14 is the largest legal select.
`ifdef XBAR_CFG_RANGE_CHECK_EN
    expect_st("range_f0", mux_m, 0, 0, 1, 1);
    send_range(img_r, 0, 7, 7);
    check_st();
`else
    expect_st("range_f0", mux_m, 1, 0, 0, 0);
    send_range(img_r, 0, 7, 7);
    check_st();
    expect_st("commit_f0", img_r, 0, 1, 0, 1);
    do_commit();
    check_st();
    mux_m = img_r;
`endif
    expect_st("range_ee", mux_m, 1, 0, 0, 0);
    send_range(img_e, 0, 7, 7);
    check_st();
    expect_st("abort_ee", mux_m, 0, 0, 0, 1);
    io_abort = 1'b1;
    tick();
    io_abort = 1'b0;
    check_st();

    // Reset mid-load clears the active image too.
    send_range(img_a, 0, 3, 7);
    expect_st("reset_mid", 64'd0, 0, 0, 0, 1);
    reset = 1'b1;
    tick();
    check_st();
    reset = 1'b0;
    mux_m = '0;
    expect_st("after_reset", mux_m, 0, 0, 0, 1);
    tick();
    check_st();
    expect_st("load_after_reset", mux_m, 1, 0, 0, 0);
    send_range(img_a, 0, 7, 7);
    check_st();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/xbar_cfg_ctrl.md
# xbar_cfg_ctrl

Configuration sequencer for the LUT-tile input crossbar. It accepts the crossbar's mux-select bitstream as a stream of narrow words over a valid/ready handshake and assembles it in a shadow register. It applies the image atomically to the crossbar's `io_mux_configs` on a commit strobe. It sits between the tile configuration chain and the `xbar` datapath, so the crossbar never sees a partially written select set.

## Interface
- `N_IN`, 15 — crossbar input count; select values `>= N_IN` are illegal.
- `N_OUT`, 16 — crossbar output count.
- `SEL_W`, 4 — select field width per output.
- `WORD_W`, 8 — config stream word width. `N_OUT*SEL_W` is a multiple of `WORD_W`, and `WORD_W` is a multiple of `SEL_W`.
- Derived: `CFG_W = N_OUT*SEL_W` (64); `NWORDS = CFG_W/WORD_W` (8).

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `io_cfg_valid` in 1 — config word valid.
- `io_cfg_ready` out 1 — controller can accept a word.
- `io_cfg_data` in `WORD_W` — config word.
- `io_cfg_last` in 1 — marks the final word of an image.
- `io_commit` in 1 — apply the pending shadow image.
- `io_abort` in 1 — discard any partial or pending image.
- `io_mux_configs` out `CFG_W` — active selects to the crossbar; field i occupies bits `[i*SEL_W +: SEL_W]`.
- `io_cfg_pending` out 1 — a complete, valid image is waiting for commit.
- `io_cfg_done` out 1 — one-cycle pulse when a commit takes effect.
- `io_cfg_err` out 1 — sticky error flag for the last load attempt.

## Operation
- The FSM has three states: IDLE, LOAD and HOLD. Reset places it in IDLE.
- A beat is accepted when `io_cfg_valid & io_cfg_ready`. `io_cfg_ready = 1` in IDLE and LOAD and `0` in HOLD.
- The word counter `wcnt` has `$clog2(NWORDS)` bits.
  - Beat k writes `shadow[k*WORD_W +: WORD_W]`. Word 0 carries the LSBs.
- **IDLE:** an accepted beat writes word 0, sets `wcnt=1`, clears `io_cfg_err` and moves to LOAD. If `NWORDS==1` and `last=1`, the beat is handled as the final word below.
- **LOAD:** each accepted beat writes word `wcnt` and increments `wcnt`.
  - `io_cfg_last` must be 1 exactly on word `NWORDS-1`.
  - Early `last`, or missing `last` on word `NWORDS-1`, sets `io_cfg_err`. The FSM returns to IDLE, the shadow image is discarded and `io_mux_configs` is unchanged.
  - A correct final word with no error moves the FSM to HOLD, which sets `io_cfg_pending=1`.
- **HOLD:** `io_commit` loads `io_mux_configs <= shadow`, pulses `io_cfg_done`, clears pending and moves to IDLE.
- `io_commit` is ignored in IDLE and LOAD.
- `io_abort` in any state returns the FSM to IDLE, clears pending and leaves `io_mux_configs` unchanged. `io_cfg_err` is not set by an abort.
- Simultaneous events:
  - `io_abort` and `io_commit` in HOLD: abort wins.
  - `io_abort` and an accepted beat: abort wins and the beat is dropped.

## Timing
- Reset values: `io_mux_configs=0` (every output selects input 0), `io_cfg_pending=0`, `io_cfg_done=0`, `io_cfg_err=0`, state IDLE, `wcnt=0`.
- `io_cfg_ready` is 1 in the first cycle after `reset` deasserts.
- `reset` mid-LOAD or in HOLD returns the block to the full reset values, including the active image.
- Throughput is one word per cycle with no bubbles between words.
- Minimum cycles from first beat to pending: `NWORDS` (8).
- All outputs are registered. `io_cfg_ready` is decoded only from the state register.
- `io_mux_configs` and `io_cfg_done` change in the cycle after `io_commit` is sampled, and they change together.
- `io_cfg_err` rises in the cycle after the offending beat. It holds until the next IDLE-accepted beat or `reset`.
- `io_cfg_pending` rises in the cycle after the final beat.

## Configuration
- Macro: `XBAR_CFG_RANGE_CHECK_EN`.
- **Defined:** each accepted word is split into `WORD_W/SEL_W` fields.
  - Any field `>= N_IN` sets an internal flag for the current load.
  - On a correctly framed final word with the flag set, the load completes as an error: `io_cfg_err=1`, FSM to IDLE, no HOLD.
  - The flag clears on entry to IDLE.
- **Undefined:** no field checking. Out-of-range selects are committed as-is, and the crossbar's out-of-range behaviour applies.

## Test plan
- **Normal load and commit:** send 8 beats `0x10,0x32,0x54,0x76,0x98,0xBA,0xDC,0x0E` with `last` on beat 7, then `io_commit`.
  - `io_cfg_pending=1` in the cycle after beat 7.
  - In the cycle after commit: `io_mux_configs=64'h0EDCBA9876543210` and `io_cfg_done` pulses for exactly 1 cycle.
- **Framing error:** send `last` on beat 3.
  - `io_cfg_err=1` in the next cycle, FSM back in IDLE, `io_mux_configs` still 0, `pending=0`.
  - Next, send 8 beats `0x00` with `last` on beat 7: `io_cfg_err` clears on the first beat and `pending=1` after beat 7.
- **Abort:** load a full image, then assert `io_abort` and `io_commit` together in HOLD.
  - `pending=0`, no `done` pulse, `io_mux_configs` unchanged.
- **Range check (macro defined):** send 8 beats of `0xF0` with `last` on beat 7.
  - `io_cfg_err=1`, `pending=0`, no HOLD.
  - With the macro undefined, the same stimulus reaches `pending=1` and commits `64'hF0F0F0F0F0F0F0F0`.
- **Backpressure and reset:** in HOLD, `io_cfg_ready=0` and a held `io_cfg_valid` is not consumed.
  - Assert `reset` mid-LOAD after 4 beats: next cycle all outputs are 0 and `io_cfg_ready` is 1.
